// File: rtl/hough_acc_scanner.sv
// Hough accumulator scanner: streams every (r, phi, cnt) bin at or above a vote threshold to the max finder.
// Optional read-and-clear of each bin is enabled by defining HOUGH_SCAN_CLEAR_EN.
module hough_acc_scanner #(
  parameter int MSB_PHI = 7,
  parameter int MSB_R   = 11,
  parameter int MSB_CNT = 15,
  parameter int PHI_NUM = 180,
  parameter int R_NUM   = 4096
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [MSB_CNT:0]         cnt_min,
  output logic                     busy,
  output logic                     done,
  output logic [MSB_PHI+MSB_R+1:0] mem_addr,
  output logic                     mem_rd,
  input  logic [MSB_CNT:0]         mem_rdata,
  output logic                     mem_we,
  output logic [MSB_PHI+MSB_R+1:0] mem_waddr,
  output logic [MSB_R:0]           r_out,
  output logic [MSB_PHI:0]         phi_out,
  output logic [MSB_CNT:0]         cnt_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [MSB_PHI+MSB_R+1:0] cand_num
);

  localparam int                 AW       = MSB_PHI + MSB_R + 2;
  localparam logic [MSB_R:0]     R_LAST   = (MSB_R + 1)'(R_NUM - 1);
  localparam logic [MSB_PHI:0]   PHI_LAST = (MSB_PHI + 1)'(PHI_NUM - 1);
  localparam logic [MSB_R:0]     R_ONE    = (MSB_R + 1)'(1);
  localparam logic [MSB_PHI:0]   PHI_ONE  = (MSB_PHI + 1)'(1);
  localparam logic [AW-1:0]      CAND_ONE = AW'(1);
  localparam logic [AW-1:0]      CAND_MAX = {AW{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [MSB_R:0]   r_idx_q, r_idx_d;
  logic [MSB_PHI:0] phi_idx_q, phi_idx_d;
  logic [MSB_CNT:0] cnt_min_q, cnt_min_d;
  logic [AW-1:0]    cand_q, cand_d;
  logic             done_q, done_d;
  logic             pend_q;
  logic [MSB_R:0]   pend_r_q;
  logic [MSB_PHI:0] pend_phi_q;
  logic [MSB_R:0]   fifo_r_q   [2];
  logic [MSB_PHI:0] fifo_phi_q [2];
  logic [MSB_CNT:0] fifo_cnt_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       count_q, count_d;
  logic [1:0]       occ_left_s;
  logic             push_s, pop_s, issue_s, last_s;

  assign out_valid = (count_q != 2'd0);
  assign pop_s     = out_valid & out_ready;
  assign push_s    = pend_q & (mem_rdata >= cnt_min_q);
  assign last_s    = (phi_idx_q == PHI_LAST) && (r_idx_q == R_LAST);
  assign count_d   = count_q + {1'b0, push_s} - {1'b0, pop_s};

  // Occupancy is taken after this cycle's pop so a departing head frees its slot for a full-rate stream.
  assign occ_left_s = count_q - {1'b0, pop_s};
  assign issue_s    = (state_q == S_SCAN) && ((occ_left_s + {1'b0, pend_q}) < 2'd2);

  assign r_out   = fifo_r_q[rd_ptr_q];
  assign phi_out = fifo_phi_q[rd_ptr_q];
  assign cnt_out = fifo_cnt_q[rd_ptr_q];
  assign done     = done_q;
  assign cand_num = cand_q;

`ifdef HOUGH_SCAN_CLEAR_EN
  assign mem_we    = pend_q;
  assign mem_waddr = {pend_phi_q, pend_r_q};
`else
  assign mem_we    = 1'b0;
  assign mem_waddr = {AW{1'b0}};
`endif

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; drain ends once nothing is in flight and the buffer will be empty
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_SCAN;
        else       state_d = S_IDLE;
      end
      S_SCAN: begin
        if (issue_s && last_s) state_d = S_DRAIN;
        else                   state_d = S_SCAN;
      end
      S_DRAIN: begin
        if (count_d == 2'd0) state_d = S_IDLE;
        else                 state_d = S_DRAIN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    mem_rd   = issue_s;
    mem_addr = {phi_idx_q, r_idx_q};
    busy     = (state_q != S_IDLE);
    if ((state_q == S_DRAIN) && (state_d == S_IDLE)) done_d = 1'b1;
    else                                             done_d = 1'b0;
  end

  // Scan index, threshold and candidate-count next state
  always_comb begin
    r_idx_d   = r_idx_q;
    phi_idx_d = phi_idx_q;
    cnt_min_d = cnt_min_q;
    cand_d    = cand_q;
    if ((state_q == S_IDLE) && start) begin
      r_idx_d   = {(MSB_R + 1){1'b0}};
      phi_idx_d = {(MSB_PHI + 1){1'b0}};
      cnt_min_d = cnt_min;
      cand_d    = {AW{1'b0}};
    end else begin
      if (issue_s) begin
        if (r_idx_q == R_LAST) begin
          r_idx_d   = {(MSB_R + 1){1'b0}};
          phi_idx_d = phi_idx_q + PHI_ONE;
        end else begin
          r_idx_d   = r_idx_q + R_ONE;
        end
      end else begin
        r_idx_d = r_idx_q;
      end
      if (pop_s && (cand_q != CAND_MAX)) cand_d = cand_q + CAND_ONE;
      else                               cand_d = cand_q;
    end
  end

  // Datapath registers: scan state, in-flight read tag and the two-entry candidate buffer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idx_q    <= {(MSB_R + 1){1'b0}};
      phi_idx_q  <= {(MSB_PHI + 1){1'b0}};
      cnt_min_q  <= {(MSB_CNT + 1){1'b0}};
      cand_q     <= {AW{1'b0}};
      done_q     <= 1'b0;
      pend_q     <= 1'b0;
      pend_r_q   <= {(MSB_R + 1){1'b0}};
      pend_phi_q <= {(MSB_PHI + 1){1'b0}};
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_r_q[i]   <= {(MSB_R + 1){1'b0}};
        fifo_phi_q[i] <= {(MSB_PHI + 1){1'b0}};
        fifo_cnt_q[i] <= {(MSB_CNT + 1){1'b0}};
      end
    end else begin
      r_idx_q   <= r_idx_d;
      phi_idx_q <= phi_idx_d;
      cnt_min_q <= cnt_min_d;
      cand_q    <= cand_d;
      done_q    <= done_d;
      pend_q    <= issue_s;
      count_q   <= count_d;
      if (issue_s) begin
        pend_r_q   <= r_idx_q;
        pend_phi_q <= phi_idx_q;
      end
      if (push_s) begin
        fifo_r_q[wr_ptr_q]   <= pend_r_q;
        fifo_phi_q[wr_ptr_q] <= pend_phi_q;
        fifo_cnt_q[wr_ptr_q] <= mem_rdata;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (pop_s) rd_ptr_q <= ~rd_ptr_q;
    end
  end

endmodule
